dlsc_pcie_s6_outbound_read_alloc: RTL and testbench

DLSC_PCIE_S6_OUTBOUND_READ_ALLOC -- requirements
Module: dlsc_pcie_s6_outbound_read_alloc

---
 rtl/dlsc_pcie_s6_outbound_read_alloc.sv | 111 +++++++++++
 tb/tb_dlsc_pcie_s6_outbound_read_alloc.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlsc_pcie_s6_outbound_read_alloc.sv
// Outbound PCIe read tag/buffer allocator: hands out the lowest free tag when the completion
// buffer has room and returns the space on retire. Optional retire checking: DLSC_PCIE_S6_OB_READ_ALLOC_CHECK_EN.
module dlsc_pcie_s6_outbound_read_alloc #(
    parameter int  ADDR   = 32,
    parameter int  TAGS   = 8,
    parameter int  BUF_DW = 1024,
    localparam int TAGB   = $clog2(TAGS)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            tlp_h_ready,
    input  logic            tlp_h_valid,
    input  logic [ADDR-1:2] tlp_h_addr,
    input  logic [9:0]      tlp_h_len,
    input  logic            tx_ready,
    output logic            tx_valid,
    output logic [ADDR-1:2] tx_addr,
    output logic [9:0]      tx_len,
    output logic [TAGB-1:0] tx_tag,
    input  logic            cpl_done,
    input  logic [TAGB-1:0] cpl_tag,
    output logic            rd_busy,
    output logic            err_unexp
);

    localparam int SPW = $clog2(BUF_DW + 1);

    logic [TAGS-1:0]       outstanding;
    logic [TAGS-1:0][10:0] tag_len;
    logic [SPW-1:0]        space;

    logic [10:0]     need;
    logic            any_free;
    logic [TAGB-1:0] free_tag;
    logic            accept;
    logic            retire;
    logic [TAGS-1:0] out_next;
    logic [SPW-1:0]  space_next;

    assign need = (tlp_h_len == 10'd0) ? 11'd1024 : {1'b0, tlp_h_len};

    // Descending scan so the last hit is the lowest-numbered free tag.
    always_comb begin
        any_free = 1'b0;
        free_tag = '0;
        for (int i = TAGS - 1; i >= 0; i--) begin
            if (!outstanding[i]) begin
                any_free = 1'b1;
                free_tag = TAGB'(i);
            end
        end
    end

    assign tlp_h_ready = !rst && (!tx_valid || tx_ready) && any_free && (SPW'(need) <= space);
    assign accept      = tlp_h_ready && tlp_h_valid;

`ifdef DLSC_PCIE_S6_OB_READ_ALLOC_CHECK_EN
    assign retire = cpl_done && outstanding[cpl_tag];

    always_ff @(posedge clk) begin
        if (rst)
            err_unexp <= 1'b0;
        else if (cpl_done && !outstanding[cpl_tag])
            err_unexp <= 1'b1;
    end
`else
    assign retire    = cpl_done;
    assign err_unexp = 1'b0;
`endif

    // Retire is applied before allocate; the allocated tag is always one that was free pre-edge.
    always_comb begin
        out_next   = outstanding;
        space_next = space;
        if (retire) begin
            out_next[cpl_tag] = 1'b0;
            space_next        = space_next + SPW'(tag_len[cpl_tag]);
        end
        if (accept) begin
            out_next[free_tag] = 1'b1;
            space_next         = space_next - SPW'(need);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            space       <= SPW'(BUF_DW);
            tx_valid    <= 1'b0;
            rd_busy     <= 1'b0;
        end else begin
            outstanding <= out_next;
            space       <= space_next;
            rd_busy     <= |out_next;
            if (accept)
                tx_valid <= 1'b1;
            else if (tx_ready)
                tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_len[free_tag] <= need;
            tx_addr           <= tlp_h_addr;
            tx_len            <= tlp_h_len;
            tx_tag            <= free_tag;
        end
    end

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_read_alloc.sv
// Self-checking bench for dlsc_pcie_s6_outbound_read_alloc: directed scenarios plus randomized
// traffic against a tag/space bookkeeping model.
module tb_dlsc_pcie_s6_outbound_read_alloc;

    localparam int ADDR   = 32;
    localparam int TAGS   = 8;
    localparam int BUF_DW = 1024;
    localparam int TAGB   = $clog2(TAGS);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tlp_h_ready;
    logic            tlp_h_valid = 1'b0;
    logic [ADDR-1:2] tlp_h_addr = '0;
    logic [9:0]      tlp_h_len = '0;
    logic            tx_ready = 1'b0;
    logic            tx_valid;
    logic [ADDR-1:2] tx_addr;
    logic [9:0]      tx_len;
    logic [TAGB-1:0] tx_tag;
    logic            cpl_done = 1'b0;
    logic [TAGB-1:0] cpl_tag = '0;
    logic            rd_busy;
    logic            err_unexp;

    int checks = 0;
    int errors = 0;

    // Reference model: which tags are in flight, how much each holds, and free buffer DW.
    bit              m_out[TAGS];
    int              m_len[TAGS];
    int              m_space = BUF_DW;
    bit              m_txv = 0;
    logic [ADDR-1:2] m_addr;
    logic [9:0]      m_tlen;
    int              m_tag;
    bit              m_err = 0;

    dlsc_pcie_s6_outbound_read_alloc #(.ADDR(ADDR), .TAGS(TAGS), .BUF_DW(BUF_DW)) dut (
        .clk(clk), .rst(rst),
        .tlp_h_ready(tlp_h_ready), .tlp_h_valid(tlp_h_valid),
        .tlp_h_addr(tlp_h_addr), .tlp_h_len(tlp_h_len),
        .tx_ready(tx_ready), .tx_valid(tx_valid),
        .tx_addr(tx_addr), .tx_len(tx_len), .tx_tag(tx_tag),
        .cpl_done(cpl_done), .cpl_tag(cpl_tag),
        .rd_busy(rd_busy), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    function automatic int req_size(input logic [9:0] l);
        return (l == 0) ? 1024 : int'(l);
    endfunction

    function automatic int lowest_free();
        for (int t = 0; t < TAGS; t++) if (!m_out[t]) return t;
        return -1;
    endfunction

    function automatic bit m_ready();
        if (rst) return 0;
        return (!m_txv || tx_ready) && (lowest_free() >= 0) && (req_size(tlp_h_len) <= m_space);
    endfunction

    function automatic bit m_busy();
        for (int t = 0; t < TAGS; t++) if (m_out[t]) return 1;
        return 0;
    endfunction

    // Advance one clock, applying the model's view of the same edge; returns #1 after it.
    task automatic tick();
        bit acc, ret, bad;
        int ft, need, ct;
        acc  = tlp_h_valid && m_ready();
        ft   = lowest_free();
        need = req_size(tlp_h_len);
        ct   = int'(cpl_tag);
        ret  = cpl_done && m_out[ct];
        bad  = cpl_done && !m_out[ct];
        @(posedge clk);
        if (rst) begin
            for (int t = 0; t < TAGS; t++) m_out[t] = 0;
            m_space = BUF_DW;
            m_txv   = 0;
            m_err   = 0;
        end else begin
            if (ret) begin
                m_out[ct] = 0;
                m_space  += m_len[ct];
            end
            if (acc) begin
                m_out[ft] = 1;
                m_len[ft] = need;
                m_space  -= need;
                m_txv     = 1;
                m_addr    = tlp_h_addr;
                m_tlen    = tlp_h_len;
                m_tag     = ft;
            end else if (tx_ready) begin
                m_txv = 0;
            end
`ifdef DLSC_PCIE_S6_OB_READ_ALLOC_CHECK_EN
            if (bad) m_err = 1;
`endif
        end
        #1;
    endtask

    // Drain the tx slot and retire every in-flight tag.
    task automatic clear_all();
        tlp_h_valid = 0;
        tx_ready    = 1;
        for (int t = 0; t < TAGS; t++) begin
            if (m_out[t]) begin
                cpl_done = 1;
                cpl_tag  = TAGB'(t);
                tick();
            end
        end
        cpl_done = 0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1; tlp_h_valid = 1; tlp_h_len = 10'd16; tx_ready = 1;
        tick();
        tick();
        #1;
        checks++; if (tlp_h_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", tlp_h_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
        checks++; if (rd_busy !== 1'b0) begin errors++; $display("FAIL rst_rd_busy got %b exp 0", rd_busy); end
        checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_unexp); end
        tlp_h_valid = 0;
        rst = 0;
        #1;
        checks++; if (tlp_h_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", tlp_h_ready); end
        tick();
    endtask

    task automatic test_back_to_back();
        tx_ready = 1; tlp_h_valid = 1; tlp_h_len = 10'd16;
        for (int i = 0; i < 9; i++) begin
            tlp_h_addr = (ADDR-2)'(32'h100 + i);
            #1;
            checks++; if (tlp_h_ready !== (i < 8)) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", i, tlp_h_ready, i < 8); end
            tick();
            if (i < 8) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_tag !== TAGB'(i) || tx_addr !== (ADDR-2)'(32'h100 + i)) begin
                    errors++; $display("FAIL b2b_tx[%0d] got v=%b tag=%0d addr=%0h exp v=1 tag=%0d addr=%0h", i, tx_valid, tx_tag, tx_addr, i, 32'h100 + i);
                end
            end
        end
        #1;
        checks++; if (tlp_h_ready !== 1'b0 || rd_busy !== 1'b1) begin errors++; $display("FAIL b2b_full got ready=%b busy=%b exp ready=0 busy=1", tlp_h_ready, rd_busy); end
        clear_all();
    endtask

    task automatic test_space();
        tx_ready = 1; tlp_h_valid = 1; tlp_h_len = 10'd0; tlp_h_addr = (ADDR-2)'(32'h2000);
        #1;
        checks++; if (tlp_h_ready !== 1'b1) begin errors++; $display("FAIL space_full_ready got %b exp 1", tlp_h_ready); end
        tick();
        checks++; if (tx_tag !== TAGB'(0) || tx_len !== 10'd0) begin errors++; $display("FAIL space_1024_tx got tag=%0d len=%0d exp tag=0 len=0", tx_tag, tx_len); end
        tlp_h_len = 10'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (tlp_h_ready !== 1'b0) begin errors++; $display("FAIL space_stall[%0d] got %b exp 0", i, tlp_h_ready); end
            tick();
        end
        cpl_done = 1; cpl_tag = '0;
        #1;
        checks++; if (tlp_h_ready !== 1'b0) begin errors++; $display("FAIL space_same_cycle got %b exp 0", tlp_h_ready); end
        tick();
        cpl_done = 0;
        #1;
        checks++; if (tlp_h_ready !== 1'b1) begin errors++; $display("FAIL space_after_retire got %b exp 1", tlp_h_ready); end
        tick();
        checks++; if (tx_valid !== 1'b1 || tx_tag !== TAGB'(0) || tx_len !== 10'd1) begin errors++; $display("FAIL space_reuse_tx got v=%b tag=%0d len=%0d exp v=1 tag=0 len=1", tx_valid, tx_tag, tx_len); end
        clear_all();
    endtask

    task automatic test_stall();
        int xfers;
        tx_ready = 0; tlp_h_valid = 1; tlp_h_len = 10'd8; tlp_h_addr = (ADDR-2)'(32'hABC);
        tick();
        tlp_h_addr = (ADDR-2)'(32'hDEF);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (tlp_h_ready !== 1'b0 || tx_valid !== 1'b1 || tx_addr !== (ADDR-2)'(32'hABC) || tx_len !== 10'd8 || tx_tag !== TAGB'(0)) begin
                errors++; $display("FAIL stall_hold[%0d] got rdy=%b v=%b addr=%0h len=%0d tag=%0d exp rdy=0 v=1 addr=abc len=8 tag=0", i, tlp_h_ready, tx_valid, tx_addr, tx_len, tx_tag);
            end
            tick();
        end
        tlp_h_valid = 0; tx_ready = 1;
        xfers = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (tx_valid && tx_ready) xfers++;
            tick();
        end
        checks++; if (xfers !== 1) begin errors++; $display("FAIL stall_xfers got %0d exp 1", xfers); end
        clear_all();
    endtask

    task automatic test_full_retire();
        tx_ready = 1; tlp_h_valid = 1; tlp_h_len = 10'd4;
        for (int i = 0; i < TAGS; i++) tick();
        cpl_done = 1; cpl_tag = TAGB'(3);
        #1;
        checks++; if (tlp_h_ready !== 1'b0) begin errors++; $display("FAIL full_cycle_n got %b exp 0", tlp_h_ready); end
        tick();
        cpl_done = 0;
        #1;
        checks++; if (tlp_h_ready !== 1'b1) begin errors++; $display("FAIL full_cycle_n1 got %b exp 1", tlp_h_ready); end
        tick();
        checks++; if (tx_tag !== TAGB'(3) || tx_valid !== 1'b1) begin errors++; $display("FAIL full_reuse_tag got v=%b tag=%0d exp v=1 tag=3", tx_valid, tx_tag); end
        clear_all();
    endtask

    task automatic test_reset_mid();
        tx_ready = 1; tlp_h_valid = 1; tlp_h_len = 10'd32;
        for (int i = 0; i < 4; i++) tick();
        tlp_h_valid = 0; tx_ready = 0;
        #1;
        checks++; if (tx_valid !== 1'b1 || rd_busy !== 1'b1) begin errors++; $display("FAIL mid_pre got v=%b busy=%b exp v=1 busy=1", tx_valid, rd_busy); end
        rst = 1;
        tick();
        checks++; if (tx_valid !== 1'b0 || rd_busy !== 1'b0) begin errors++; $display("FAIL mid_rst got v=%b busy=%b exp v=0 busy=0", tx_valid, rd_busy); end
        rst = 0; tlp_h_valid = 1; tlp_h_len = 10'd0;
        #1;
        checks++; if (tlp_h_ready !== 1'b1) begin errors++; $display("FAIL mid_space got ready=%b exp 1", tlp_h_ready); end
        tick();
        checks++; if (tx_tag !== TAGB'(0)) begin errors++; $display("FAIL mid_tag got %0d exp 0", tx_tag); end
        clear_all();
    endtask

`ifdef DLSC_PCIE_S6_OB_READ_ALLOC_CHECK_EN
    task automatic test_check();
        tlp_h_valid = 0; cpl_done = 1; cpl_tag = TAGB'(5);
        tick();
        cpl_done = 0;
        checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL chk_err got %b exp 1", err_unexp); end
        tlp_h_valid = 1; tlp_h_len = 10'd0;
        #1;
        checks++; if (tlp_h_ready !== 1'b1) begin errors++; $display("FAIL chk_space got %b exp 1", tlp_h_ready); end
        tlp_h_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL chk_clear got %b exp 0", err_unexp); end
        tick();
    endtask
`endif

    task automatic test_random();
        int busy[$];
        for (int n = 0; n < 400; n++) begin
            tlp_h_valid = ($urandom % 2) != 0;
            tlp_h_len   = ($urandom % 8 == 0) ? 10'd0 : 10'($urandom_range(1, 300));
            tlp_h_addr  = (ADDR-2)'($urandom);
            tx_ready    = ($urandom % 4) != 0;
            busy.delete();
            for (int t = 0; t < TAGS; t++) if (m_out[t]) busy.push_back(t);
            cpl_done = (busy.size() > 0) && ($urandom % 3 == 0);
            cpl_tag  = (busy.size() > 0) ? TAGB'(busy[$urandom % busy.size()]) : '0;
            #1;
            checks++; if (tlp_h_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", n, tlp_h_ready, m_ready()); end
            tick();
            checks++;
            if (tx_valid !== m_txv || rd_busy !== m_busy() || err_unexp !== m_err) begin
                errors++; $display("FAIL rnd_flags[%0d] got v=%b busy=%b err=%b exp v=%b busy=%b err=%b", n, tx_valid, rd_busy, err_unexp, m_txv, m_busy(), m_err);
            end
            if (m_txv) begin
                checks++;
                if (tx_addr !== m_addr || tx_len !== m_tlen || tx_tag !== TAGB'(m_tag)) begin
                    errors++; $display("FAIL rnd_tx[%0d] got addr=%0h len=%0d tag=%0d exp addr=%0h len=%0d tag=%0d", n, tx_addr, tx_len, tx_tag, m_addr, m_tlen, m_tag);
                end
            end
        end
        cpl_done = 0;
        clear_all();
    endtask

    initial begin
        for (int t = 0; t < TAGS; t++) begin m_out[t] = 0; m_len[t] = 0; end
        test_reset();
        test_back_to_back();
        test_space();
        test_stall();
        test_full_retire();
        test_reset_mid();
`ifdef DLSC_PCIE_S6_OB_READ_ALLOC_CHECK_EN
        test_check();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
